// File: rtl/arb_pkg.sv
// Shared types and default widths for the round-robin memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    // A single-port arbiter still carries a 1-bit pointer.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_grant_sel.sv
// Rotate-priority picker: first requester at or after rr_ptr, wrapping modulo N_PORTS.
// Purely combinational, zero latency; no backpressure.
module rr_grant_sel #(
    parameter int N_PORTS = 2,
    parameter int PTR_W   = 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any_req
);

    int              j;
    logic [PTR_W-1:0] idx;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        j         = 0;
        idx       = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N_PORTS) j = j - N_PORTS;
            idx = PTR_W'(j);
            if (req[idx]) begin
                grant_idx = idx;
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter onto one memory port; req->mem_enable 1 cycle, mem_ack->ack 1 cycle.
// Clients hold req until their ack pulse; BUSY waits on mem_ack (bounded when ARB_TIMEOUT_EN is defined).
module mem_arbiter_rr #(
    parameter int N_PORTS        = 2,
    parameter int ADDR_W         = arb_pkg::ADDR_W,
    parameter int DATA_W         = arb_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS-1:0]        rw,
    input  logic [N_PORTS*ADDR_W-1:0] addr,
    input  logic [N_PORTS*DATA_W-1:0] wdata,
    output logic [N_PORTS-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_enable,
    output logic                      mem_rw,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data_in,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_data_out
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                      err
`endif
);

    import arb_pkg::*;

    localparam int PTR_W = ptr_w(N_PORTS);

    if (N_PORTS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_arbiter_rr: N_PORTS and TIMEOUT_CYCLES must be >= 1");
    end

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_idx_q, grant_idx_d;
    logic [N_PORTS-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               mem_enable_q, mem_enable_d;
    logic               mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_data_in_q, mem_data_in_d;

    logic [PTR_W-1:0]   sel_idx;
    logic               any_req;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    rr_grant_sel #(
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W)
    ) u_sel (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (sel_idx),
        .any_req   (any_req)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_idx_d   = grant_idx_q;
        ack_d         = ack_q;
        rdata_d       = rdata_q;
        mem_enable_d  = mem_enable_q;
        mem_rw_d      = mem_rw_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_d         = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                mem_enable_d = 1'b0;
                if (any_req) begin
                    grant_idx_d   = sel_idx;
                    mem_rw_d      = rw[sel_idx];
                    mem_addr_d    = addr[sel_idx*ADDR_W +: ADDR_W];
                    mem_data_in_d = wdata[sel_idx*DATA_W +: DATA_W];
                    mem_enable_d  = 1'b1;
                    state_d       = BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_enable_d         = 1'b0;
                    if (!mem_rw_q) rdata_d = mem_data_out;
                    ack_d                = '0;
                    ack_d[grant_idx_q]   = 1'b1;
                    state_d              = DONE;
`ifdef ARB_TIMEOUT_EN
                    err_d                = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Give up on memory: complete the client with err, rdata untouched.
                    mem_enable_d         = 1'b0;
                    ack_d                = '0;
                    ack_d[grant_idx_q]   = 1'b1;
                    err_d                = 1'b1;
                    state_d              = DONE;
                end else begin
                    cnt_d                = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                ack_d    = '0;
                rr_ptr_d = (grant_idx_q == PTR_W'(N_PORTS - 1)) ? '0 : grant_idx_q + 1'b1;
                state_d  = IDLE;
`ifdef ARB_TIMEOUT_EN
                err_d    = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_idx_q   <= '0;
            ack_q         <= '0;
            rdata_q       <= '0;
            mem_enable_q  <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_idx_q   <= grant_idx_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            mem_enable_q  <= mem_enable_d;
            mem_rw_q      <= mem_rw_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            err_q         <= err_d;
`endif
        end
    end

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign mem_enable  = mem_enable_q;
    assign mem_rw      = mem_rw_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
`ifdef ARB_TIMEOUT_EN
    assign err         = err_q;
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench: a 2-port and a 3-port arbiter on a shared clock, checked against hand-computed values.
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Two-port instance
    logic [1:0]   req2, rw2, ack2;
    logic [63:0]  addr2;
    logic [255:0] wdata2;
    logic [127:0] rdata2, mem_data_in2, mem_data_out2;
    logic         mem_enable2, mem_rw2, mem_ack2;
    logic [31:0]  mem_addr2;
`ifdef ARB_TIMEOUT_EN
    logic         err2, err3;
`endif

    // Three-port instance
    logic [2:0]   req3, rw3, ack3;
    logic [95:0]  addr3;
    logic [383:0] wdata3;
    logic [127:0] rdata3, mem_data_in3, mem_data_out3;
    logic         mem_enable3, mem_rw3, mem_ack3;
    logic [31:0]  mem_addr3;

    mem_arbiter_rr #(.N_PORTS(2), .TIMEOUT_CYCLES(4)) u2 (
        .clk(clk), .reset(reset), .req(req2), .rw(rw2), .addr(addr2), .wdata(wdata2),
        .ack(ack2), .rdata(rdata2), .mem_enable(mem_enable2), .mem_rw(mem_rw2),
        .mem_addr(mem_addr2), .mem_data_in(mem_data_in2), .mem_ack(mem_ack2),
        .mem_data_out(mem_data_out2)
`ifdef ARB_TIMEOUT_EN
        , .err(err2)
`endif
    );

    mem_arbiter_rr #(.N_PORTS(3)) u3 (
        .clk(clk), .reset(reset), .req(req3), .rw(rw3), .addr(addr3), .wdata(wdata3),
        .ack(ack3), .rdata(rdata3), .mem_enable(mem_enable3), .mem_rw(mem_rw3),
        .mem_addr(mem_addr3), .mem_data_in(mem_data_in3), .mem_ack(mem_ack3),
        .mem_data_out(mem_data_out3)
`ifdef ARB_TIMEOUT_EN
        , .err(err3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req2 = '0; rw2 = '0; addr2 = '0; wdata2 = '0; mem_ack2 = 1'b0; mem_data_out2 = '0;
        req3 = '0; rw3 = '0; addr3 = '0; wdata3 = '0; mem_ack3 = 1'b0; mem_data_out3 = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (mem_enable2 !== 1'b0) begin bad++; $display("FAIL rst_en2 got=%b exp=0", mem_enable2); end
        total++; if (ack2 !== 2'b00) begin bad++; $display("FAIL rst_ack2 got=%b exp=00", ack2); end
        total++; if (mem_addr2 !== 32'h0 || mem_rw2 !== 1'b0) begin bad++; $display("FAIL rst_addr2 got=%h/%b exp=0/0", mem_addr2, mem_rw2); end
        total++; if (rdata2 !== 128'h0 || mem_data_in2 !== 128'h0) begin bad++; $display("FAIL rst_data2 got=%h/%h exp=0", rdata2, mem_data_in2); end
        total++; if (u2.rr_ptr_q !== 1'b0) begin bad++; $display("FAIL rst_ptr2 got=%b exp=0", u2.rr_ptr_q); end
        total++; if (mem_enable3 !== 1'b0 || ack3 !== 3'b000) begin bad++; $display("FAIL rst_u3 got=%b/%b exp=0/000", mem_enable3, ack3); end
    endtask

    task automatic test_write_slow_ack();
        req2[0] = 1'b1; rw2[0] = 1'b1; addr2[31:0] = 32'h100; wdata2[127:0] = {16{8'hA5}};
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++; if (mem_enable2 !== 1'b1 || mem_rw2 !== 1'b1 || mem_addr2 !== 32'h100) begin
                bad++; $display("FAIL wr_busy_c%0d got=%b/%b/%h exp=1/1/100", c, mem_enable2, mem_rw2, mem_addr2); end
            total++; if (mem_data_in2 !== {16{8'hA5}}) begin bad++; $display("FAIL wr_wdata_c%0d got=%h exp=a5..a5", c, mem_data_in2); end
            total++; if (ack2 !== 2'b00) begin bad++; $display("FAIL wr_noack_c%0d got=%b exp=00", c, ack2); end
        end
        mem_ack2 = 1'b1;
        tick();
        mem_ack2 = 1'b0; req2[0] = 1'b0;
        total++; if (ack2 !== 2'b01 || mem_enable2 !== 1'b0) begin bad++; $display("FAIL wr_ack got=%b/%b exp=01/0", ack2, mem_enable2); end
        total++; if (rdata2 !== 128'h0) begin bad++; $display("FAIL wr_rdata_kept got=%h exp=0", rdata2); end
        tick();
        total++; if (ack2 !== 2'b00) begin bad++; $display("FAIL wr_ack_width got=%b exp=00", ack2); end
        total++; if (u2.rr_ptr_q !== 1'b1) begin bad++; $display("FAIL wr_ptr got=%b exp=1", u2.rr_ptr_q); end
    endtask

    task automatic test_read_fast_ack();
        req2[1] = 1'b1; rw2[1] = 1'b0; addr2[63:32] = 32'h200;
        tick();
        total++; if (mem_enable2 !== 1'b1 || mem_rw2 !== 1'b0 || mem_addr2 !== 32'h200) begin
            bad++; $display("FAIL rd_launch got=%b/%b/%h exp=1/0/200", mem_enable2, mem_rw2, mem_addr2); end
        mem_ack2 = 1'b1; mem_data_out2 = {4{32'hDEADBEEF}};
        tick();
        mem_ack2 = 1'b0; req2[1] = 1'b0; mem_data_out2 = '0;
        total++; if (ack2 !== 2'b10) begin bad++; $display("FAIL rd_ack got=%b exp=10", ack2); end
        total++; if (rdata2 !== {4{32'hDEADBEEF}}) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef x4", rdata2); end
        tick();
        total++; if (ack2 !== 2'b00 || u2.rr_ptr_q !== 1'b0) begin bad++; $display("FAIL rd_done got=%b/%b exp=00/0", ack2, u2.rr_ptr_q); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req2 = 2'b11; rw2 = 2'b00; addr2 = {32'h400, 32'h300}; mem_ack2 = 1'b1; mem_data_out2 = 128'h55;
        tick();
        total++; if (mem_enable2 !== 1'b1 || mem_addr2 !== 32'h300) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/300", mem_enable2, mem_addr2); end
        tick();
        req2[0] = 1'b0;
        total++; if (ack2 !== 2'b01) begin bad++; $display("FAIL b2b_ack0 got=%b exp=01", ack2); end
        tick();
        total++; if (ack2 !== 2'b00 || mem_enable2 !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b/%b exp=00/0", ack2, mem_enable2); end
        tick();
        total++; if (mem_enable2 !== 1'b1 || mem_addr2 !== 32'h400) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/400", mem_enable2, mem_addr2); end
        tick();
        req2[1] = 1'b0; mem_ack2 = 1'b0;
        total++; if (ack2 !== 2'b10) begin bad++; $display("FAIL b2b_ack1 got=%b exp=10", ack2); end
        tick();
    endtask

    task automatic test_rr_three();
        logic [2:0] exp_ack [5];
        exp_ack[0] = 3'b001; exp_ack[1] = 3'b010; exp_ack[2] = 3'b100; exp_ack[3] = 3'b001; exp_ack[4] = 3'b010;
        req3 = 3'b111; rw3 = 3'b000; addr3 = {32'h3000, 32'h2000, 32'h1000}; mem_ack3 = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
            total++; if (mem_enable3 !== 1'b1 || ack3 !== 3'b000) begin bad++; $display("FAIL rr3_launch_g%0d got=%b/%b exp=1/000", g, mem_enable3, ack3); end
            tick();
            total++; if (ack3 !== exp_ack[g]) begin bad++; $display("FAIL rr3_ack_g%0d got=%b exp=%b", g, ack3, exp_ack[g]); end
            tick();
            total++; if (ack3 !== 3'b000) begin bad++; $display("FAIL rr3_pulse_g%0d got=%b exp=000", g, ack3); end
        end
        req3 = '0; mem_ack3 = 1'b0;
    endtask

    task automatic test_reset_in_busy();
        req2[0] = 1'b1; rw2[0] = 1'b0; addr2[31:0] = 32'h500;
        tick();
        total++; if (mem_enable2 !== 1'b1) begin bad++; $display("FAIL rib_busy got=%b exp=1", mem_enable2); end
        reset = 1'b1; req2 = '0;
        tick();
        reset = 1'b0;
        total++; if (mem_enable2 !== 1'b0 || ack2 !== 2'b00 || mem_addr2 !== 32'h0) begin
            bad++; $display("FAIL rib_cleared got=%b/%b/%h exp=0/00/0", mem_enable2, ack2, mem_addr2); end
        tick();
        mem_ack2 = 1'b1;
        tick();
        mem_ack2 = 1'b0;
        total++; if (ack2 !== 2'b00) begin bad++; $display("FAIL rib_late_ack got=%b exp=00", ack2); end
        tick();
        total++; if (ack2 !== 2'b00 || mem_enable2 !== 1'b0) begin bad++; $display("FAIL rib_quiet got=%b/%b exp=00/0", ack2, mem_enable2); end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        req2[0] = 1'b1; rw2[0] = 1'b0; addr2[31:0] = 32'h600;
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++; if (mem_enable2 !== 1'b1 || ack2 !== 2'b00) begin bad++; $display("FAIL to_wait_c%0d got=%b/%b exp=1/00", c, mem_enable2, ack2); end
        end
        tick();
        req2[0] = 1'b0;
        total++; if (ack2 !== 2'b01 || err2 !== 1'b1 || mem_enable2 !== 1'b0) begin
            bad++; $display("FAIL to_fire got=%b/%b/%b exp=01/1/0", ack2, err2, mem_enable2); end
        total++; if (rdata2 !== 128'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", rdata2); end
        tick();
        total++; if (err2 !== 1'b0) begin bad++; $display("FAIL to_err_clear got=%b exp=0", err2); end
        req2[1] = 1'b1; rw2[1] = 1'b0; mem_ack2 = 1'b1;
        tick();
        tick();
        req2[1] = 1'b0; mem_ack2 = 1'b0;
        total++; if (ack2 !== 2'b10 || err2 !== 1'b0) begin bad++; $display("FAIL to_normal got=%b/%b exp=10/0", ack2, err2); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write_slow_ack();
        test_read_fast_ack();
        test_back_to_back();
        test_rr_three();
        test_reset_in_busy();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-port memory arbiter. Successor to the fixed two-client (Icache read, Dcache read/write) arbiter in the cpu top.
- Sits between any number of cache miss/writeback ports and the single external memory port (mem_enable/mem_rw/mem_ack).
- Grants one transaction at a time using round-robin fairness, and registers all outputs to memory and back to clients.

Parameters:
N_PORTS, 2, number of requesting clients (>=1)
ADDR_W, 32, address width (matches REG_SIZE)
DATA_W, 128, line width (matches WIDTH)
TIMEOUT_CYCLES, 255, cycles to wait for mem_ack (used only with optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req  in  N_PORTS  per-port request; held high until that port's ack
rw  in  N_PORTS  per-port direction, 1=write 0=read
addr  in  N_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
wdata  in  N_PORTS*DATA_W  per-port write line
ack  out  N_PORTS  one-cycle completion pulse, one-hot
rdata  out  DATA_W  read line, valid while ack is high
mem_enable  out  1  memory request
mem_rw  out  1  1=write
mem_addr  out  ADDR_W  memory address
mem_data_in  out  DATA_W  write data to memory
mem_ack  in  1  memory completion
mem_data_out  in  DATA_W  read data from memory

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE, mem_enable=0, mem_rw=0, mem_addr=0, mem_data_in=0, ack=0, rdata=0, rr_ptr=0, grant_idx=0.
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - If any req bit is high, grant_idx is the first index with req high, scanning rr_ptr, rr_ptr+1, ... and wrapping modulo N_PORTS.
  - Latch rw, addr and wdata of grant_idx into the mem_* registers, set mem_enable=1, go to BUSY.
  - If no req, stay in IDLE with mem_enable=0.
- BUSY:
  - mem_enable, mem_rw, mem_addr and mem_data_in stay stable until mem_ack=1.
  - On mem_ack=1: mem_enable<=0; rdata<=mem_data_out for reads, unchanged for writes; ack[grant_idx]<=1; go to DONE.
- DONE:
  - ack is high for exactly this one cycle.
  - rr_ptr<=(grant_idx==N_PORTS-1)?0:grant_idx+1.
  - ack<=0, go to IDLE.
- Latency: req high in IDLE at cycle 0 -> mem_enable at cycle 1 -> mem_ack at cycle k>=1 -> ack at cycle k+1. Minimum 2 cycles.
- Requester rule: req must be low in the cycle after ack is high. A req still high in IDLE is treated as a new request.
- Changes to the non-granted ports' req/addr during BUSY have no effect.
- mem_ack while in IDLE or DONE is ignored.
- N_PORTS=1: rr_ptr is constant 0.
- Pointer width is $clog2(N_PORTS) with a minimum of 1.
- Reset during BUSY or DONE:
  - Next cycle all outputs hold their reset values and no ack is issued.
  - The in-flight memory access is abandoned.
  - A late mem_ack is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - Adds output port err (1 bit, reset 0) and a counter cleared on entry to BUSY.
  - If the counter reaches TIMEOUT_CYCLES without mem_ack, mem_enable<=0 and ack[grant_idx]<=1 with err=1 in DONE; rdata is unchanged.
  - err is 0 on normal completions.
- When undefined: no err port, no counter; BUSY waits indefinitely.

Decomposition:
- Shared package arb_pkg holds the state encoding (IDLE, BUSY, DONE) and the default width constants ADDR_W and DATA_W.
- One sub-module, rr_grant_sel: combinational rotate-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant_idx, any_req.

Test Plan:
- N=2: port0 write, addr=0x100, wdata=0xA5..A5, mem_ack 3 cycles after mem_enable -> mem_enable high 3 cycles with mem_rw=1 and mem_addr=0x100; ack=2'b01 pulse one cycle later; rr_ptr=1.
- N=2: port1 read at 0x200, mem_data_out=0xDEADBEEF_...; mem_ack at cycle 1 -> ack=2'b10 at cycle 2 with rdata=0xDEADBEEF_...
- N=2: req=2'b11 right after reset -> port0 served first, then port1, no idle gap beyond DONE; acks 01 then 10.
- N=3: all ports requesting continuously with mem_ack=1 -> grant order 0,1,2,0,1; each ack is one-hot and one cycle wide.
- Reset asserted in BUSY -> next cycle mem_enable=0 and ack=0; a mem_ack pulse 2 cycles later produces no ack.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack held 0 -> ack pulse with err=1 after 4 BUSY cycles; next request completes with err=0.
